// File: rtl/dump_pkg.sv
// Shared types and constants for the dump trace capture block.
package dump_pkg;

    // Capture controller states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_e;

    // Buffer-full policy selected by the Mode input.
    localparam logic MODE_STOP = 1'b0;
    localparam logic MODE_WRAP = 1'b1;

    // Largest field widths a trace entry may carry (NUM_CH<=8, TS_W<=32, DATA_W<=64).
    localparam int unsigned CH_W_MAX   = 3;
    localparam int unsigned TS_W_MAX   = 32;
    localparam int unsigned DATA_W_MAX = 64;

    // Decoded trace entry; narrower configurations zero-extend into it.
    typedef struct packed {
        logic [CH_W_MAX-1:0]   ch;
        logic [TS_W_MAX-1:0]   ts;
        logic [DATA_W_MAX-1:0] data;
    } trace_entry_t;

endpackage

// File: rtl/dump_trace_ram.sv
// Trace storage: simple dual-port array, one write port and one registered read port.
module dump_trace_ram #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write port; contents are not reset so the array can map onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Registered read port: data for raddr appears the cycle after re.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dump_trace_capture.sv
// Captures handshakes on monitored valid/ready channels into a trace buffer
// during a DumpStart..DumpEnd window, then streams the entries out oldest first.
module dump_trace_capture
    import dump_pkg::*;
#(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned TS_W   = 16,
    parameter int unsigned CNT_W  = 32,
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     DumpStart,
    input  logic                     DumpEnd,
    input  logic                     Mode,
    input  logic [NUM_CH-1:0]        Ch_En,
    input  logic [NUM_CH-1:0]        Ch_Val,
    input  logic [NUM_CH-1:0]        Ch_Rdy,
    input  logic [NUM_CH*DATA_W-1:0] Ch_Data,
    output logic                     Trc_Val,
    input  logic                     Trc_Rdy,
    output logic [DATA_W-1:0]        Trc_Data,
    output logic [CH_W-1:0]          Trc_Ch,
    output logic [TS_W-1:0]          Trc_Ts,
    output logic                     Busy,
    output logic                     Wrapped,
    output logic [CNT_W-1:0]         Cap_Cnt,
    output logic [CNT_W-1:0]         Drop_Cnt
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned ENT_W = CH_W + TS_W + DATA_W;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    // Registered state
    state_e           state_q,    state_d;
    logic             mode_q,     mode_d;
    logic [TS_W-1:0]  ts_q,       ts_d;
    logic [AW-1:0]    wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q,   rd_ptr_d;
    logic [AW:0]      cnt_q,      cnt_d;
    logic             wrapped_q,  wrapped_d;
    logic [CNT_W-1:0] cap_cnt_q,  cap_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    trace_entry_t     out_q,      out_d;
    logic             out_val_q,  out_val_d;
    trace_entry_t     skid_q,     skid_d;
    logic             skid_val_q, skid_val_d;
    logic             rd_pend_q,  rd_pend_d;

    // Arbitration results
    logic [NUM_CH-1:0] fire;
    logic              any_fire;
    logic [3:0]        n_fire;
    logic [CH_W-1:0]   win_idx;
    logic [DATA_W-1:0] win_data;

    // Window bookkeeping
    logic             accept;
    logic             capturing;
    logic             mode_cur;
    logic [TS_W-1:0]  ts_cur;
    logic [AW:0]      cnt_b;
    logic [AW-1:0]    wr_ptr_b;
    logic [AW-1:0]    rd_ptr_b;
    logic [CNT_W-1:0] cap_b;
    logic [CNT_W-1:0] drop_b;
    logic             wrapped_b;
    logic [3:0]       drop_inc;
    logic [CNT_W:0]   drop_sum;

    // Readout
    logic             pop;
    logic [1:0]       occ;
    logic [1:0]       occ_after;
    logic             issue;
    logic             drain_done;

    // RAM interface
    logic             ram_we;
    logic [AW-1:0]    ram_waddr;
    logic [ENT_W-1:0] ram_wdata;
    logic             ram_re;
    logic [ENT_W-1:0] ram_rdata;
    trace_entry_t     rd_ent;

    logic             unused_ent_hi;

    dump_trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_ram (
        .clk   (Clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    // Per-cycle fire vector, lowest-index winner and number of firing channels.
    always_comb begin
        fire     = Ch_Val & Ch_Rdy & Ch_En;
        any_fire = |fire;
        n_fire   = '0;
        win_idx  = '0;
        win_data = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            n_fire = n_fire + 4'(fire[i]);
        end
        // Scan from the top so the lowest firing index is the last one kept.
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (fire[NUM_CH-1-i]) begin
                win_idx  = CH_W'(NUM_CH - 1 - i);
                win_data = Ch_Data[DATA_W*(NUM_CH-1-i) +: DATA_W];
            end
        end
    end

    // Unpack a RAM word into the decoded entry used by the readout registers.
    always_comb begin
        rd_ent      = '0;
        rd_ent.ch   = CH_W_MAX'(ram_rdata[ENT_W-1 -: CH_W]);
        rd_ent.ts   = TS_W_MAX'(ram_rdata[DATA_W +: TS_W]);
        rd_ent.data = DATA_W_MAX'(ram_rdata[DATA_W-1:0]);
    end

    // Next-state logic: FSM, capture/write path and prefetching readout.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        ts_d       = ts_q;
        out_d      = out_q;
        out_val_d  = out_val_q;
        skid_d     = skid_q;
        skid_val_d = skid_val_q;
        ram_we     = 1'b0;
        ram_waddr  = '0;
        ram_wdata  = '0;
        drop_inc   = '0;

        accept    = (state_q == ST_IDLE) && DumpStart;
        capturing = accept || (state_q == ST_CAPTURE);

        // A DumpStart accept clears the window state in the same cycle, so the
        // beat captured that cycle is applied on top of zeroed bases.
        mode_cur  = accept ? Mode : mode_q;
        ts_cur    = accept ? '0 : ts_q;
        cnt_b     = accept ? '0 : cnt_q;
        wr_ptr_b  = accept ? '0 : wr_ptr_q;
        rd_ptr_b  = accept ? '0 : rd_ptr_q;
        cap_b     = accept ? '0 : cap_cnt_q;
        drop_b    = accept ? '0 : drop_cnt_q;
        wrapped_b = accept ? 1'b0 : wrapped_q;

        cnt_d     = cnt_b;
        wr_ptr_d  = wr_ptr_b;
        rd_ptr_d  = rd_ptr_b;
        cap_cnt_d = cap_b;
        wrapped_d = wrapped_b;

        if (accept) begin
            mode_d = Mode;
            ts_d   = TS_W'(1);
        end else if (state_q == ST_CAPTURE) begin
            ts_d = (ts_q == '1) ? ts_q : ts_q + TS_W'(1);
        end

        if (capturing && any_fire) begin
            drop_inc  = n_fire - 4'd1;
            ram_waddr = wr_ptr_b;
            ram_wdata = {win_idx, ts_cur, win_data};
            if (cnt_b != FULL_CNT) begin
                ram_we    = 1'b1;
                wr_ptr_d  = wr_ptr_b + AW'(1);
                cnt_d     = cnt_b + (AW + 1)'(1);
                cap_cnt_d = (cap_b == '1) ? cap_b : cap_b + CNT_W'(1);
            end else if (mode_cur == MODE_WRAP) begin
                // Full: the write slot is the oldest entry, so both pointers step.
                ram_we    = 1'b1;
                wr_ptr_d  = wr_ptr_b + AW'(1);
                rd_ptr_d  = rd_ptr_b + AW'(1);
                wrapped_d = 1'b1;
                cap_cnt_d = (cap_b == '1) ? cap_b : cap_b + CNT_W'(1);
            end else begin
                drop_inc = n_fire;
            end
        end

        drop_sum   = {1'b0, drop_b} + (CNT_W + 1)'(drop_inc);
        drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];

        // Readout keeps up to two entries (output + skid) counting the read in
        // flight, so a new read may issue whenever one slot will be free.
        pop       = out_val_q && Trc_Rdy;
        occ       = {1'b0, out_val_q} + {1'b0, skid_val_q} + {1'b0, rd_pend_q};
        occ_after = occ - {1'b0, pop};
        issue     = (state_q == ST_DRAIN) && (cnt_q != '0) && (occ_after < 2'd2);
        ram_re    = issue;
        rd_pend_d = issue;
        if (issue) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            cnt_d    = cnt_q - (AW + 1)'(1);
        end

        if (!out_val_q || pop) begin
            if (skid_val_q) begin
                out_d      = skid_q;
                out_val_d  = 1'b1;
                skid_d     = rd_ent;
                skid_val_d = rd_pend_q;
            end else if (rd_pend_q) begin
                out_d     = rd_ent;
                out_val_d = 1'b1;
            end else begin
                out_val_d = 1'b0;
            end
        end else if (rd_pend_q) begin
            skid_d     = rd_ent;
            skid_val_d = 1'b1;
        end

        drain_done = (cnt_q == '0) && !skid_val_q && !rd_pend_q && (!out_val_q || pop);

        unique case (state_q)
            ST_IDLE:    if (DumpStart) state_d = DumpEnd ? ST_DRAIN : ST_CAPTURE;
            ST_CAPTURE: if (DumpEnd) state_d = ST_DRAIN;
            ST_DRAIN:   if (drain_done) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_STOP;
            ts_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            wrapped_q  <= 1'b0;
            cap_cnt_q  <= '0;
            drop_cnt_q <= '0;
            out_q      <= '0;
            out_val_q  <= 1'b0;
            skid_q     <= '0;
            skid_val_q <= 1'b0;
            rd_pend_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            ts_q       <= ts_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            wrapped_q  <= wrapped_d;
            cap_cnt_q  <= cap_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            out_q      <= out_d;
            out_val_q  <= out_val_d;
            skid_q     <= skid_d;
            skid_val_q <= skid_val_d;
            rd_pend_q  <= rd_pend_d;
        end
    end

    assign Trc_Val  = out_val_q;
    assign Trc_Data = out_q.data[DATA_W-1:0];
    assign Trc_Ch   = out_q.ch[CH_W-1:0];
    assign Trc_Ts   = out_q.ts[TS_W-1:0];
    assign Busy     = (state_q != ST_IDLE);
    assign Wrapped  = wrapped_q;
    assign Cap_Cnt  = cap_cnt_q;
    assign Drop_Cnt = drop_cnt_q;

    // Upper entry bits are zero-extension only and never reach a port.
    assign unused_ent_hi = ^out_q;

endmodule

// File: tb/tb_dump_trace_capture.sv
// Scoreboard bench for dump_trace_capture (3 channels, 16-bit data, depth 8, 8-bit ts).
module tb_dump_trace_capture;

    localparam int unsigned NUM_CH = 3;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned TS_W   = 8;
    localparam int unsigned CNT_W  = 32;

    typedef struct packed {
        logic [1:0]  ch;
        logic [7:0]  ts;
        logic [15:0] data;
    } ent_t;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        DumpStart, DumpEnd, Mode;
    logic [2:0]  Ch_En, Ch_Val, Ch_Rdy;
    logic [47:0] Ch_Data;
    logic        Trc_Val, Trc_Rdy;
    logic [15:0] Trc_Data;
    logic [1:0]  Trc_Ch;
    logic [7:0]  Trc_Ts;
    logic        Busy, Wrapped;
    logic [31:0] Cap_Cnt, Drop_Cnt;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;

    // Reference model state for the current window
    ent_t        mq[$];
    ent_t        exp_q[$];
    int unsigned m_cap, m_drop;
    bit          m_wrap;

    // Beat bookkeeping from the monitor
    bit          arm;
    bit          have_first;
    time         first_t, last_t;
    bit          stall_prev;
    ent_t        held;

    // Directed fire plans
    logic [2:0]  plan_v [16];
    logic [15:0] plan_d [16][3];

    dump_trace_capture #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .TS_W   (TS_W),
        .CNT_W  (CNT_W)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .DumpStart (DumpStart),
        .DumpEnd   (DumpEnd),
        .Mode      (Mode),
        .Ch_En     (Ch_En),
        .Ch_Val    (Ch_Val),
        .Ch_Rdy    (Ch_Rdy),
        .Ch_Data   (Ch_Data),
        .Trc_Val   (Trc_Val),
        .Trc_Rdy   (Trc_Rdy),
        .Trc_Data  (Trc_Data),
        .Trc_Ch    (Trc_Ch),
        .Trc_Ts    (Trc_Ts),
        .Busy      (Busy),
        .Wrapped   (Wrapped),
        .Cap_Cnt   (Cap_Cnt),
        .Drop_Cnt  (Drop_Cnt)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each transfer and checks output hold during stalls.
    always @(negedge Clk) begin
        ent_t got;
        ent_t want;
        got = {Trc_Ch, Trc_Ts, Trc_Data};
        if (Rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                compared++;
                if (!(Trc_Val === 1'b1 && got === held)) begin
                    mismatched++;
                    $display("FAIL hold: got val=%0b ent=0x%0h expected val=1 ent=0x%0h",
                             Trc_Val, got, held);
                end
            end
            if (Trc_Val === 1'b1 && arm && !have_first) begin
                have_first = 1'b1;
                first_t    = $time;
            end
            if (Trc_Val === 1'b1 && Trc_Rdy === 1'b1) begin
                compared++;
                last_t = $time;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL beat: got unexpected ent=0x%0h expected no beat", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        mismatched++;
                        $display("FAIL beat: got ch=%0d ts=%0d data=0x%0h expected ch=%0d ts=%0d data=0x%0h",
                                 Trc_Ch, Trc_Ts, Trc_Data, want.ch, want.ts, want.data);
                    end
                end
            end
            stall_prev = (Trc_Val === 1'b1) && (Trc_Rdy !== 1'b1);
            held       = got;
        end
    end

    // Reference: lowest firing channel wins, others dropped; full buffer stops or overwrites oldest.
    task automatic model_cycle(input bit mode, input int unsigned ts);
        logic [2:0]  f;
        int unsigned n;
        ent_t        e;
        f = Ch_Val & Ch_Rdy & Ch_En;
        n = $countones(f);
        if (n == 0) return;
        e.ts = 8'((ts > 255) ? 255 : ts);
        e.ch = '0;
        e.data = '0;
        for (int c = 2; c >= 0; c--) begin
            if (f[c]) begin
                e.ch   = 2'(c);
                e.data = Ch_Data[16*c +: 16];
            end
        end
        m_drop += n - 1;
        if (mq.size() < DEPTH) begin
            mq.push_back(e);
            m_cap++;
        end else if (mode) begin
            void'(mq.pop_front());
            mq.push_back(e);
            m_cap++;
            m_wrap = 1'b1;
        end else begin
            m_drop++;
        end
    endtask

    task automatic clear_plan();
        for (int unsigned k = 0; k < 16; k++) begin
            plan_v[k] = '0;
            for (int unsigned c = 0; c < 3; c++) plan_d[k][c] = '0;
        end
    endtask

    task automatic randomize_channels();
        Ch_Val  = 3'($urandom);
        Ch_Rdy  = 3'($urandom);
        Ch_En   = 3'($urandom) | 3'($urandom);
        Ch_Data = {16'($urandom), 16'($urandom), 16'($urandom)};
    endtask

    // One capture window of len cycles, then drain; rdy_mode 0=high, 1=random, 2=1-0-0-1.
    task automatic run_window(input bit mode, input int unsigned len, input bit use_plan,
                              input int unsigned rdy_mode);
        time         t_end;
        int unsigned n_exp;
        bit          done;
        mq.delete();
        exp_q.delete();
        m_cap = 0; m_drop = 0; m_wrap = 1'b0;
        have_first = 1'b0;
        arm = 1'b1;
        for (int unsigned k = 0; k < len; k++) begin
            @(posedge Clk); #1;
            DumpStart = (k == 0) ? 1'b1 : ($urandom_range(0, 7) == 0);
            DumpEnd   = (k == len - 1);
            Mode      = (k == 0) ? mode : 1'($urandom);
            Trc_Rdy   = 1'($urandom);
            if (use_plan) begin
                Ch_En  = '1;
                Ch_Rdy = '1;
                Ch_Val = (k < 16) ? plan_v[k] : 3'b000;
                Ch_Data = (k < 16) ? {plan_d[k][2], plan_d[k][1], plan_d[k][0]} : '0;
            end else begin
                randomize_channels();
            end
            model_cycle(mode, k);
        end
        @(posedge Clk);
        t_end = $time;
        #1;
        DumpStart = 1'b0;
        DumpEnd   = 1'b0;
        n_exp = mq.size();
        foreach (mq[i]) exp_q.push_back(mq[i]);
        done = 1'b0;
        for (int unsigned c = 0; c < 300 && !done; c++) begin
            case (rdy_mode)
                0:       Trc_Rdy = 1'b1;
                1:       Trc_Rdy = 1'($urandom);
                default: Trc_Rdy = ((c % 4) == 0) || ((c % 4) == 3);
            endcase
            randomize_channels();
            DumpEnd = 1'($urandom);
            @(negedge Clk);
            if (Busy === 1'b0) done = 1'b1;
            else begin
                @(posedge Clk); #1;
            end
        end
        arm = 1'b0;
        DumpEnd = 1'b0;
        Ch_Val  = '0;
        if (!done) begin
            compared++;
            mismatched++;
            $display("FAIL drain_timeout: got Busy=1 after 300 cycles expected Busy=0");
        end
        check("all_delivered", 64'(exp_q.size()), 64'd0);
        check("cap_cnt", 64'(Cap_Cnt), 64'(m_cap));
        check("drop_cnt", 64'(Drop_Cnt), 64'(m_drop));
        check("wrapped", 64'(Wrapped), 64'(m_wrap));
        if (n_exp > 0) begin
            check("first_val_latency_ok", 64'((first_t - t_end) <= 25), 64'd1);
            if (rdy_mode == 0) begin
                check("back_to_back", 64'(last_t - first_t), 64'((n_exp - 1) * 10));
            end
        end
        exp_q.delete();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst = 1'b1; DumpStart = 1'b0; DumpEnd = 1'b0; Mode = 1'b0;
        Ch_En = '0; Ch_Val = '0; Ch_Rdy = '0; Ch_Data = '0; Trc_Rdy = 1'b0;
        arm = 1'b0; stall_prev = 1'b0; have_first = 1'b0;
        first_t = 0; last_t = 0;
        repeat (3) @(posedge Clk);
        #1;
        Rst = 1'b0;
        @(negedge Clk);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_trc_val", 64'(Trc_Val), 64'd0);
        check("rst_wrapped", 64'(Wrapped), 64'd0);
        check("rst_cap", 64'(Cap_Cnt), 64'd0);
        check("rst_drop", 64'(Drop_Cnt), 64'd0);

        // ch1 fires 0xA5A5 at ts 3, window closes at ts 5
        clear_plan();
        plan_v[3] = 3'b010; plan_d[3][1] = 16'hA5A5;
        run_window(1'b0, 6, 1'b1, 0);
        check("single_cap", 64'(Cap_Cnt), 64'd1);
        check("single_busy", 64'(Busy), 64'd0);

        // ch0 and ch2 collide
        clear_plan();
        plan_v[1] = 3'b101; plan_d[1][0] = 16'h1111; plan_d[1][2] = 16'h2222;
        run_window(1'b0, 4, 1'b1, 0);
        check("collide_drop", 64'(Drop_Cnt), 64'd1);
        check("collide_cap", 64'(Cap_Cnt), 64'd1);

        // ten fires into depth 8, stop and wrap policies
        clear_plan();
        for (int unsigned k = 1; k <= 10; k++) begin
            plan_v[k] = 3'b001;
            plan_d[k][0] = 16'(k - 1);
        end
        run_window(1'b0, 12, 1'b1, 0);
        check("stop_cap", 64'(Cap_Cnt), 64'd8);
        check("stop_drop", 64'(Drop_Cnt), 64'd2);
        check("stop_wrapped", 64'(Wrapped), 64'd0);
        run_window(1'b1, 12, 1'b1, 0);
        check("wrap_cap", 64'(Cap_Cnt), 64'd10);
        check("wrap_wrapped", 64'(Wrapped), 64'd1);

        // four entries drained under a 1-0-0-1 ready pattern
        clear_plan();
        for (int unsigned k = 0; k < 4; k++) begin
            plan_v[2*k] = 3'b100;
            plan_d[2*k][2] = 16'hC000 + 16'(k);
        end
        run_window(1'b0, 8, 1'b1, 2);

        // start and end in the same cycle captures that beat
        clear_plan();
        plan_v[0] = 3'b110; plan_d[0][1] = 16'hBEEF; plan_d[0][2] = 16'hDEAD;
        run_window(1'b1, 1, 1'b1, 1);
        check("one_cycle_cap", 64'(Cap_Cnt), 64'd1);

        // reset in the middle of a window abandons its entries
        @(posedge Clk); #1;
        DumpStart = 1'b1; Mode = 1'b0; Ch_En = '1; Ch_Rdy = '1; Ch_Val = 3'b001;
        Ch_Data = {32'd0, 16'h7777};
        repeat (2) begin
            @(posedge Clk); #1;
            DumpStart = 1'b0;
            Ch_Data = {32'd0, 16'($urandom)};
        end
        @(posedge Clk); #1;
        Ch_Val = '0; Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        @(negedge Clk);
        check("midrst_busy", 64'(Busy), 64'd0);
        check("midrst_cap", 64'(Cap_Cnt), 64'd0);
        check("midrst_trc_val", 64'(Trc_Val), 64'd0);
        @(negedge Clk);
        check("midrst_trc_val_next", 64'(Trc_Val), 64'd0);
        clear_plan();
        run_window(1'b0, 5, 1'b1, 0);
        check("post_rst_cap", 64'(Cap_Cnt), 64'd0);

        // randomized windows
        for (int unsigned w = 0; w < 30; w++) begin
            run_window(1'($urandom), $urandom_range(1, 24), 1'b0, $urandom_range(0, 2));
        end
        // long window exercises timestamp saturation
        run_window(1'b1, 280, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
